// File: rtl/mig_arb_pkg.sv
// Shared types and constants for the MIG Native Interface arbiter.
// Optional statistics counters are enabled by defining MIG_ARB_STATS_EN.
package mig_arb_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } arb_state_t;

    // MIG app_cmd encodings the arbiter cares about
    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;

    // Client ids are sized for the largest supported client count (4)
    localparam int MAX_CLIENTS = 4;
    localparam int CLIENT_ID_W = $clog2(MAX_CLIENTS);
    typedef logic [CLIENT_ID_W-1:0] client_id_t;

    // Round-robin distance of a candidate from the client after the last owner:
    // 0 means "next in line", n-1 means "last in line".
    function automatic int rr_distance(input int cand, input int last, input int n);
        return (cand + n - last - 1) % n;
    endfunction

endpackage

// File: rtl/mig_arb_tag_fifo.sv
// Synchronous FIFO of client ids recording which client issued each
// outstanding read. Head is visible combinationally so returning read data
// can be routed in the same cycle it arrives. Push and pop may coincide.
module mig_arb_tag_fifo
    import mig_arb_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  client_id_t               push_id,
    input  logic                     pop,
    output client_id_t               head_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    client_id_t      mem [DEPTH];
    logic [AW:0]     wr_ptr_reg;
    logic [AW:0]     rd_ptr_reg;
    logic            push_ok;
    logic            pop_ok;

    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then
    assign push_ok = push && (!full || pop_ok);
    assign head_id = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset because pointers define validity
    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_id;
        end
    end

    // Pointer update; reset flushes all outstanding tags
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mig_native_arbiter.sv
// Round-robin, burst-granular arbiter sharing one MIG Native Interface between
// NUM_CLIENTS requesters. Commands and write data follow the current grant;
// read data is routed back in order using a tag FIFO of issuing client ids.
// Define MIG_ARB_STATS_EN to add per-client stat_cmds / stat_stall counters.
module mig_native_arbiter
    import mig_arb_pkg::*;
#(
    parameter int NUM_CLIENTS        = 2,
    parameter int MIG_Data_Port_Size = 128,
    parameter int MIG_Addr_Port_Size = 28,
    parameter int Max_Grant_Cmds     = 64,
    parameter int Tag_Fifo_Depth     = 32
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,
    input  logic                                      init_calib,
    // client side
    input  logic [NUM_CLIENTS-1:0]                    c_req,
    output logic [NUM_CLIENTS-1:0]                    c_grant,
    input  logic [NUM_CLIENTS*MIG_Addr_Port_Size-1:0] c_addr,
    input  logic [NUM_CLIENTS*3-1:0]                  c_cmd,
    input  logic [NUM_CLIENTS-1:0]                    c_en,
    output logic [NUM_CLIENTS-1:0]                    c_rdy,
    input  logic [NUM_CLIENTS*MIG_Data_Port_Size-1:0] c_wdf_data,
    input  logic [NUM_CLIENTS-1:0]                    c_wdf_wren,
    input  logic [NUM_CLIENTS-1:0]                    c_wdf_end,
    output logic [NUM_CLIENTS-1:0]                    c_wdf_rdy,
    output logic [MIG_Data_Port_Size-1:0]             c_rd_data,
    output logic [NUM_CLIENTS-1:0]                    c_rd_data_valid,
    output logic [NUM_CLIENTS-1:0]                    c_rd_data_end,
    // MIG side
    output logic [MIG_Addr_Port_Size-1:0]             app_addr,
    output logic [2:0]                                app_cmd,
    output logic                                      app_en,
    input  logic                                      app_rdy,
    output logic [MIG_Data_Port_Size-1:0]             app_wdf_data,
    output logic                                      app_wdf_wren,
    output logic                                      app_wdf_end,
    input  logic                                      app_wdf_rdy,
    input  logic [MIG_Data_Port_Size-1:0]             app_rd_data,
    input  logic                                      app_rd_data_valid,
    input  logic                                      app_rd_data_end,
`ifdef MIG_ARB_STATS_EN
    output logic [NUM_CLIENTS*32-1:0]                 stat_cmds,
    output logic [NUM_CLIENTS*32-1:0]                 stat_stall,
`endif
    output logic                                      tag_err
);

    localparam int CNT_W = $clog2(Max_Grant_Cmds + 1);
    localparam int TCW   = $clog2(Tag_Fifo_Depth) + 1;

    arb_state_t                   state_reg, state_next;
    logic [NUM_CLIENTS-1:0]       grant_reg, grant_next;
    client_id_t                   owner_reg, owner_next;
    client_id_t                   last_owner_reg, last_owner_next;
    logic [CNT_W-1:0]             cmd_cnt_reg, cmd_cnt_next;
    logic signed [15:0]           wr_bal_reg, wr_bal_next;
    logic                         tag_err_reg;

    // owner-selected client signals
    logic                          owner_req;
    logic [MIG_Addr_Port_Size-1:0] owner_addr;
    logic [2:0]                    owner_cmd;
    logic                          owner_en;
    logic [MIG_Data_Port_Size-1:0] owner_wdata;
    logic                          owner_wren;
    logic                          owner_wend;

    // round-robin pick
    logic                          pick_found;
    client_id_t                    pick_id;
    logic [NUM_CLIENTS-1:0]        pick_onehot;
    int                            best_dist;

    // handshakes and tag FIFO
    logic                          in_grant;
    logic                          cap_hit;
    logic                          rd_block;
    logic                          cmd_gate;
    logic                          cmd_accept;
    logic                          wr_accept;
    logic                          rd_accept;
    logic                          wdf_done;
    logic                          exit_cond;
    client_id_t                    tag_head;
    logic                          tag_full;
    logic                          tag_empty;
    logic [TCW-1:0]                tag_count;
    logic                          tag_count_unused;
    logic                          rd_routed;
    logic                          tag_pop;

    // Select the current owner's request/command/write-data signals
    always_comb begin
        owner_req   = 1'b0;
        owner_addr  = '0;
        owner_cmd   = CMD_WRITE;
        owner_en    = 1'b0;
        owner_wdata = '0;
        owner_wren  = 1'b0;
        owner_wend  = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_reg[i]) begin
                owner_req   = c_req[i];
                owner_addr  = c_addr[i*MIG_Addr_Port_Size +: MIG_Addr_Port_Size];
                owner_cmd   = c_cmd[i*3 +: 3];
                owner_en    = c_en[i];
                owner_wdata = c_wdf_data[i*MIG_Data_Port_Size +: MIG_Data_Port_Size];
                owner_wren  = c_wdf_wren[i];
                owner_wend  = c_wdf_end[i];
            end
        end
    end

    // Find the first requester after the last owner, wrapping around
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        best_dist  = NUM_CLIENTS;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (c_req[i] && (rr_distance(i, int'(last_owner_reg), NUM_CLIENTS) < best_dist)) begin
                best_dist  = rr_distance(i, int'(last_owner_reg), NUM_CLIENTS);
                pick_id    = client_id_t'(i);
                pick_found = 1'b1;
            end
        end
    end

    // One-hot form of the picked client for the registered grant
    always_comb begin
        pick_onehot = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            pick_onehot[i] = (pick_id == client_id_t'(i));
        end
    end

    assign in_grant = |grant_reg;
    assign cap_hit  = (cmd_cnt_reg == CNT_W'(Max_Grant_Cmds));
    // Reads stall when no tag slot is free; everything stalls once the grant cap is reached
    assign rd_block = tag_full && (owner_cmd == CMD_READ);
    assign cmd_gate = in_grant && !rd_block && !cap_hit;

    assign app_addr     = owner_addr;
    assign app_cmd      = owner_cmd;
    assign app_en       = cmd_gate && owner_en;
    assign app_wdf_data = owner_wdata;
    assign app_wdf_wren = in_grant && owner_wren;
    assign app_wdf_end  = in_grant && owner_wend;

    assign c_grant   = grant_reg;
    assign c_rdy     = grant_reg & {NUM_CLIENTS{app_rdy && cmd_gate}};
    assign c_wdf_rdy = grant_reg & {NUM_CLIENTS{app_wdf_rdy}};

    assign cmd_accept = app_en && app_rdy;
    assign wr_accept  = cmd_accept && (owner_cmd == CMD_WRITE);
    assign rd_accept  = cmd_accept && (owner_cmd == CMD_READ);
    assign wdf_done   = app_wdf_end && app_wdf_rdy;

    // Release only with no write data owed, and never while a command is being taken
    assign exit_cond = (!owner_req || cap_hit) && (wr_bal_reg == 16'sd0) && !cmd_accept;

    // Outstanding write-command vs write-data balance for the current grant
    always_comb begin
        wr_bal_next = wr_bal_reg;
        case ({wr_accept, wdf_done})
            2'b10:   wr_bal_next = wr_bal_reg + 16'sd1;
            2'b01:   wr_bal_next = wr_bal_reg - 16'sd1;
            default: wr_bal_next = wr_bal_reg;
        endcase
    end

    // Next-state and grant bookkeeping
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        cmd_cnt_next    = cmd_cnt_reg + CNT_W'(cmd_accept);
        case (state_reg)
            INIT: begin
                if (init_calib) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (pick_found) begin
                    state_next = GRANT;
                    grant_next = pick_onehot;
                    owner_next = pick_id;
                end
            end
            GRANT: begin
                if (exit_cond) begin
                    state_next      = ARB;
                    grant_next      = '0;
                    last_owner_next = owner_reg;
                    cmd_cnt_next    = '0;
                end
            end
            default: begin
                state_next = INIT;
                grant_next = '0;
            end
        endcase
    end

    // Control registers; reset aborts any grant in progress
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg      <= INIT;
            grant_reg      <= '0;
            owner_reg      <= '0;
            last_owner_reg <= client_id_t'(NUM_CLIENTS - 1);
            cmd_cnt_reg    <= '0;
            wr_bal_reg     <= 16'sd0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            cmd_cnt_reg    <= cmd_cnt_next;
            wr_bal_reg     <= wr_bal_next;
        end
    end

    mig_arb_tag_fifo #(
        .DEPTH (Tag_Fifo_Depth)
    ) u_tag_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (rd_accept),
        .push_id (owner_reg),
        .pop     (tag_pop),
        .head_id (tag_head),
        .full    (tag_full),
        .empty   (tag_empty),
        .count   (tag_count)
    );

    // Occupancy stays on the FIFO port as a debug probe point
    assign tag_count_unused = ^tag_count;

    // Read returns follow the FIFO head, independent of who holds the grant now
    assign rd_routed = app_rd_data_valid && !tag_empty;
    assign tag_pop   = rd_routed && app_rd_data_end;
    assign c_rd_data = app_rd_data;

    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_route
            assign c_rd_data_valid[gi] = rd_routed && (tag_head == client_id_t'(gi));
            assign c_rd_data_end[gi]   = rd_routed && app_rd_data_end && (tag_head == client_id_t'(gi));
        end
    endgenerate

    // Sticky flag for read data that nobody asked for
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tag_err_reg <= 1'b0;
        end else if (app_rd_data_valid && tag_empty) begin
            tag_err_reg <= 1'b1;
        end
    end

    assign tag_err = tag_err_reg;

`ifdef MIG_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_stats
            logic [31:0] cmds_reg;
            logic [31:0] stall_reg;

            // Accepted-command and waiting-cycle counters, wrapping at 2^32
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    cmds_reg  <= '0;
                    stall_reg <= '0;
                end else begin
                    if (cmd_accept && grant_reg[gi]) begin
                        cmds_reg <= cmds_reg + 32'd1;
                    end
                    if (c_req[gi] && !grant_reg[gi]) begin
                        stall_reg <= stall_reg + 32'd1;
                    end
                end
            end

            assign stat_cmds[gi*32 +: 32]  = cmds_reg;
            assign stat_stall[gi*32 +: 32] = stall_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_mig_native_arbiter.sv
// Self-checking bench for mig_native_arbiter (2 clients, 16-deep tag FIFO,
// 64-command grant cap). Expected read routing comes from a queue of issuing
// clients; grant order and per-grant counts come from round-robin rules.
module tb_mig_native_arbiter;

    localparam int N  = 2;
    localparam int D  = 128;
    localparam int A  = 28;
    localparam int MC = 64;
    localparam int TD = 16;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              init_calib;
    logic [N-1:0]      c_req;
    wire  [N-1:0]      c_grant;
    logic [N*A-1:0]    c_addr;
    logic [N*3-1:0]    c_cmd;
    logic [N-1:0]      c_en;
    wire  [N-1:0]      c_rdy;
    logic [N*D-1:0]    c_wdf_data;
    logic [N-1:0]      c_wdf_wren;
    logic [N-1:0]      c_wdf_end;
    wire  [N-1:0]      c_wdf_rdy;
    wire  [D-1:0]      c_rd_data;
    wire  [N-1:0]      c_rd_data_valid;
    wire  [N-1:0]      c_rd_data_end;
    wire  [A-1:0]      app_addr;
    wire  [2:0]        app_cmd;
    wire               app_en;
    logic              app_rdy;
    wire  [D-1:0]      app_wdf_data;
    wire               app_wdf_wren;
    wire               app_wdf_end;
    logic              app_wdf_rdy;
    logic [D-1:0]      app_rd_data;
    logic              app_rd_data_valid;
    logic              app_rd_data_end;
    wire               tag_err;
`ifdef MIG_ARB_STATS_EN
    wire  [N*32-1:0]   stat_cmds;
    wire  [N*32-1:0]   stat_stall;
`endif

    int total = 0;
    int bad   = 0;
    int exp_q[$];          // client id expected for each outstanding read, oldest first
    int last_owner_model;  // last client that held a grant

    always #5 aclk = ~aclk;

    mig_native_arbiter #(
        .NUM_CLIENTS        (N),
        .MIG_Data_Port_Size (D),
        .MIG_Addr_Port_Size (A),
        .Max_Grant_Cmds     (MC),
        .Tag_Fifo_Depth     (TD)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .init_calib        (init_calib),
        .c_req             (c_req),
        .c_grant           (c_grant),
        .c_addr            (c_addr),
        .c_cmd             (c_cmd),
        .c_en              (c_en),
        .c_rdy             (c_rdy),
        .c_wdf_data        (c_wdf_data),
        .c_wdf_wren        (c_wdf_wren),
        .c_wdf_end         (c_wdf_end),
        .c_wdf_rdy         (c_wdf_rdy),
        .c_rd_data         (c_rd_data),
        .c_rd_data_valid   (c_rd_data_valid),
        .c_rd_data_end     (c_rd_data_end),
        .app_addr          (app_addr),
        .app_cmd           (app_cmd),
        .app_en            (app_en),
        .app_rdy           (app_rdy),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_end       (app_wdf_end),
        .app_wdf_rdy       (app_wdf_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data_end   (app_rd_data_end),
`ifdef MIG_ARB_STATS_EN
        .stat_cmds         (stat_cmds),
        .stat_stall        (stat_stall),
`endif
        .tag_err           (tag_err)
    );

    function automatic logic [D-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Raise a client's request and issue n read commands; records the expected return order
    task automatic issue_reads(input int id, input int n);
        int got = 0;
        int cyc = 0;
        c_req[id] = 1'b1;
        while (got < n && cyc < 400) begin
            @(negedge aclk);
            cyc++;
            c_en[id]            = 1'b1;
            c_cmd[id*3 +: 3]    = 3'd1;
            c_addr[id*A +: A]   = A'($urandom);
            app_rdy             = ($urandom_range(0, 3) != 0);
            #1;
            if (c_rdy[id]) begin
                got++;
                exp_q.push_back(id);
            end
        end
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL issue_reads client=%0d accepted=%0d required=%0d", id, got, n);
        end
        @(negedge aclk);
        c_en[id]  = 1'b0;
        c_req[id] = 1'b0;
    endtask

    // Drop all requests and wait (bounded) for the grant to be released
    task automatic release_all();
        int cyc = 0;
        @(negedge aclk);
        c_req      = '0;
        c_en       = '0;
        c_wdf_wren = '0;
        c_wdf_end  = '0;
        #1;
        while (c_grant != '0 && cyc < 30) begin
            @(negedge aclk);
            #1;
            cyc++;
        end
        total++;
        if (c_grant !== '0) begin
            bad++;
            $display("FAIL release grant=%b required=00", c_grant);
        end
    endtask

    task automatic test_reset();
        aresetn           = 1'b0;
        init_calib        = 1'b0;
        c_req             = 2'b11;
        c_en              = '0;
        c_addr            = '0;
        c_cmd             = '0;
        c_wdf_data        = '0;
        c_wdf_wren        = '0;
        c_wdf_end         = '0;
        app_rdy           = 1'b1;
        app_wdf_rdy       = 1'b1;
        app_rd_data       = '0;
        app_rd_data_valid = 1'b0;
        app_rd_data_end   = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            #1;
            total++;
            if (c_grant !== 2'b00) begin
                bad++;
                $display("FAIL reset_grant cycle=%0d grant=%b required=00", k, c_grant);
            end
        end
        total++;
        if (tag_err !== 1'b0 || app_en !== 1'b0 || c_rdy !== 2'b00 || c_wdf_rdy !== 2'b00) begin
            bad++;
            $display("FAIL reset_outputs tag_err=%b app_en=%b c_rdy=%b c_wdf_rdy=%b required=0/0/00/00",
                     tag_err, app_en, c_rdy, c_wdf_rdy);
        end
        @(negedge aclk);
        init_calib = 1'b1;
        @(negedge aclk);
        #1;
        total++;
        if (c_grant !== 2'b00) begin
            bad++;
            $display("FAIL calib_latency1 grant=%b required=00", c_grant);
        end
        @(negedge aclk);
        #1;
        total++;
        if (c_grant !== 2'b01) begin
            bad++;
            $display("FAIL calib_first_grant grant=%b required=01", c_grant);
        end
        last_owner_model = 0;
        release_all();
    endtask

    // Both clients write continuously; grants must alternate with exactly MC commands each
    task automatic test_burst();
        logic [N-1:0] prev_g = '0;
        logic [N-1:0] cur_g;
        int cnt = 0;
        int done = 0;
        int cyc = 0;
        int exp_owner = (last_owner_model + 1) % N;
        int owner;
        c_req       = 2'b11;
        c_cmd       = '0;
        app_wdf_rdy = 1'b1;
        while (done < 4 && cyc < 3000) begin
            @(negedge aclk);
            cyc++;
            c_en       = 2'b11;
            c_addr     = {A'($urandom), A'($urandom)};
            c_wdf_data = {rand_data(), rand_data()};
            app_rdy    = ($urandom_range(0, 3) != 0);
            c_wdf_wren = '0;
            c_wdf_end  = '0;
            #1;
            // write data travels with each accepted command
            c_wdf_wren = c_en & c_rdy;
            c_wdf_end  = c_en & c_rdy;
            #1;
            cur_g = c_grant;
            total++;
            if (!$onehot0(cur_g)) begin
                bad++;
                $display("FAIL burst_onehot grant=%b required=one-hot-or-zero", cur_g);
            end
            if (prev_g != '0 && cur_g != prev_g) begin
                owner = prev_g[1] ? 1 : 0;
                total++;
                if (owner != exp_owner) begin
                    bad++;
                    $display("FAIL burst_order grant#%0d owner=%0d required=%0d", done, owner, exp_owner);
                end
                total++;
                if (cnt != MC) begin
                    bad++;
                    $display("FAIL burst_count grant#%0d accepted=%0d required=%0d", done, cnt, MC);
                end
                $display("burst grant#%0d owner=%0d accepted=%0d", done, owner, cnt);
                last_owner_model = owner;
                exp_owner = (owner + 1) % N;
                done++;
                cnt = 0;
            end
            if (cur_g != '0) begin
                owner = cur_g[1] ? 1 : 0;
                if (cnt >= MC) begin
                    total++;
                    if (app_en !== 1'b0) begin
                        bad++;
                        $display("FAIL burst_cap app_en=%b required=0 after %0d cmds", app_en, cnt);
                    end
                end
                if (app_en && app_rdy) begin
                    cnt++;
                    total++;
                    if (app_addr !== c_addr[owner*A +: A] || app_wdf_data !== c_wdf_data[owner*D +: D]) begin
                        bad++;
                        $display("FAIL burst_mux addr=%h required=%h", app_addr, c_addr[owner*A +: A]);
                    end
                end
            end else begin
                total++;
                if (app_en !== 1'b0 || c_rdy !== 2'b00) begin
                    bad++;
                    $display("FAIL burst_idle app_en=%b c_rdy=%b required=0/00", app_en, c_rdy);
                end
            end
            prev_g = cur_g;
        end
        total++;
        if (done != 4) begin
            bad++;
            $display("FAIL burst_timeout grants=%0d required=4", done);
        end
        release_all();
    endtask

    // Client 0 issues 8 reads, client 1 issues 4; returns must follow issue order
    task automatic test_read_routing();
        logic [D-1:0] d;
        logic [N-1:0] expv;
        int e;
        issue_reads(0, 8);
        release_all();
        issue_reads(1, 4);
        release_all();
        total++;
        if (exp_q.size() != 12) begin
            bad++;
            $display("FAIL read_issue outstanding=%0d required=12", exp_q.size());
        end
        while (exp_q.size() > 0) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge aclk);
                app_rd_data_valid = 1'b0;
                app_rd_data_end   = 1'b0;
                #1;
                total++;
                if (c_rd_data_valid !== 2'b00) begin
                    bad++;
                    $display("FAIL read_gap valid=%b required=00", c_rd_data_valid);
                end
            end
            @(negedge aclk);
            d                 = rand_data();
            app_rd_data       = d;
            app_rd_data_valid = 1'b1;
            app_rd_data_end   = 1'b1;
            #1;
            e    = exp_q.pop_front();
            expv = N'(1 << e);
            total++;
            if (c_rd_data_valid !== expv || c_rd_data_end !== expv || c_rd_data !== d) begin
                bad++;
                $display("FAIL read_route valid=%b end=%b required=%b data_ok=%0d",
                         c_rd_data_valid, c_rd_data_end, expv, (c_rd_data === d));
            end
            $display("read return to client %0d valid=%b", e, c_rd_data_valid);
        end
        @(negedge aclk);
        app_rd_data_valid = 1'b0;
        app_rd_data_end   = 1'b0;
    endtask

    // Grant must be held while write data is still owed, then hand over
    task automatic test_wr_hold();
        int got = 0;
        int cyc = 0;
        int beats = 0;
        c_req = 2'b01;
        c_cmd = '0;
        while (got < 2 && cyc < 100) begin
            @(negedge aclk);
            cyc++;
            c_en[0]     = 1'b1;
            c_addr      = {A'(0), A'($urandom)};
            app_rdy     = ($urandom_range(0, 1) != 0);
            app_wdf_rdy = 1'b0;
            #1;
            if (c_rdy[0]) got++;
        end
        total++;
        if (got != 2) begin
            bad++;
            $display("FAIL wr_cmds accepted=%0d required=2", got);
        end
        @(negedge aclk);
        c_en        = '0;
        c_req       = 2'b10;
        c_wdf_wren  = 2'b01;
        c_wdf_end   = 2'b01;
        c_wdf_data  = {rand_data(), rand_data()};
        app_wdf_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge aclk);
            #1;
            total++;
            if (c_grant !== 2'b01 || c_wdf_rdy !== 2'b00) begin
                bad++;
                $display("FAIL wr_hold cycle=%0d grant=%b wdf_rdy=%b required=01/00", k, c_grant, c_wdf_rdy);
            end
        end
        cyc = 0;
        while (beats < 2 && cyc < 20) begin
            @(negedge aclk);
            cyc++;
            app_wdf_rdy = 1'b1;
            #1;
            if (c_wdf_rdy[0] && c_wdf_wren[0]) beats++;
        end
        @(negedge aclk);
        c_wdf_wren  = '0;
        c_wdf_end   = '0;
        app_wdf_rdy = 1'b0;
        #1;
        total++;
        if (c_grant !== 2'b01) begin
            bad++;
            $display("FAIL wr_release_lat grant=%b required=01", c_grant);
        end
        @(negedge aclk);
        #1;
        total++;
        if (c_grant !== 2'b00) begin
            bad++;
            $display("FAIL wr_release grant=%b required=00", c_grant);
        end
        @(negedge aclk);
        #1;
        total++;
        if (c_grant !== 2'b10) begin
            bad++;
            $display("FAIL wr_rearb grant=%b required=10", c_grant);
        end
        $display("write hold done beats=%0d", beats);
        release_all();
    endtask

    // Tag FIFO full blocks further reads until a return frees a slot
    task automatic test_backpressure();
        logic [D-1:0] d;
        logic [N-1:0] expv;
        int got = 0;
        int got2 = 0;
        int e;
        c_req = 2'b01;
        for (int k = 0; k < 60; k++) begin
            @(negedge aclk);
            c_en[0]    = 1'b1;
            c_cmd[2:0] = 3'd1;
            c_addr     = {A'(0), A'($urandom)};
            app_rdy    = ($urandom_range(0, 3) != 0);
            #1;
            if (c_rdy[0]) begin
                got++;
                exp_q.push_back(0);
            end
        end
        total++;
        if (got != TD) begin
            bad++;
            $display("FAIL bp_fill accepted=%0d required=%0d", got, TD);
        end
        @(negedge aclk);
        app_rdy = 1'b1;
        #1;
        total++;
        if (c_rdy !== 2'b00 || app_en !== 1'b0) begin
            bad++;
            $display("FAIL bp_block c_rdy=%b app_en=%b required=00/0", c_rdy, app_en);
        end
        // a single return frees exactly one slot
        @(negedge aclk);
        d                 = rand_data();
        app_rd_data       = d;
        app_rd_data_valid = 1'b1;
        app_rd_data_end   = 1'b1;
        #1;
        e = exp_q.pop_front();
        total++;
        if (c_rd_data_valid !== N'(1 << e) || c_rdy[0] !== 1'b0) begin
            bad++;
            $display("FAIL bp_return valid=%b c_rdy=%b required=%b/0", c_rd_data_valid, c_rdy[0], N'(1 << e));
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge aclk);
            app_rd_data_valid = 1'b0;
            app_rd_data_end   = 1'b0;
            app_rdy           = 1'b1;
            #1;
            if (c_rdy[0]) begin
                got2++;
                exp_q.push_back(0);
            end
        end
        total++;
        if (got2 != 1) begin
            bad++;
            $display("FAIL bp_refill accepted=%0d required=1", got2);
        end
        release_all();
        while (exp_q.size() > 0) begin
            @(negedge aclk);
            d                 = rand_data();
            app_rd_data       = d;
            app_rd_data_valid = 1'b1;
            app_rd_data_end   = 1'b1;
            #1;
            e    = exp_q.pop_front();
            expv = N'(1 << e);
            total++;
            if (c_rd_data_valid !== expv || c_rd_data !== d) begin
                bad++;
                $display("FAIL bp_drain valid=%b required=%b", c_rd_data_valid, expv);
            end
        end
        @(negedge aclk);
        app_rd_data_valid = 1'b0;
        app_rd_data_end   = 1'b0;
        $display("backpressure accepted=%0d then %0d", got, got2);
    endtask

    // Unexpected read data sets a sticky error and is routed nowhere
    task automatic test_tag_err();
        @(negedge aclk);
        #1;
        total++;
        if (tag_err !== 1'b0) begin
            bad++;
            $display("FAIL tag_err_pre value=%b required=0", tag_err);
        end
        @(negedge aclk);
        app_rd_data       = rand_data();
        app_rd_data_valid = 1'b1;
        app_rd_data_end   = 1'b1;
        #1;
        total++;
        if (c_rd_data_valid !== 2'b00 || c_rd_data_end !== 2'b00) begin
            bad++;
            $display("FAIL tag_err_route valid=%b end=%b required=00/00", c_rd_data_valid, c_rd_data_end);
        end
        @(negedge aclk);
        app_rd_data_valid = 1'b0;
        app_rd_data_end   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            #1;
            total++;
            if (tag_err !== 1'b1) begin
                bad++;
                $display("FAIL tag_err_sticky cycle=%0d value=%b required=1", k, tag_err);
            end
        end
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        total++;
        if (tag_err !== 1'b0 || c_grant !== 2'b00) begin
            bad++;
            $display("FAIL tag_err_reset tag_err=%b grant=%b required=0/00", tag_err, c_grant);
        end
        $display("tag_err scenario complete");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_burst();
        test_read_routing();
        test_wr_hold();
        test_backpressure();
        test_tag_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
